// File: rtl/eei_initiator_if.sv
// EEI custom-instruction bus between the core-side initiator (master) and the
// custom execution units (slave): request fields, operand array and response.
interface eei_initiator_if #(
    parameter int unsigned RS_MAX = 8,
    parameter int unsigned RD_MAX = 8
);
    logic                     eei_req;
    logic                     eei_ext;
    logic [2:0]               eei_funct3;
    logic [6:0]               eei_funct7;
    logic [4:0]               eei_batch_start;
    logic [4:0]               eei_batch_len;
    logic [RS_MAX-1:0][31:0]  eei_rs_val;
    logic                     eei_ack;
    logic                     eei_error;
    logic [1:0]               eei_rd_op;
    logic [4:0]               eei_rd_len;
    logic [RD_MAX-1:0][31:0]  eei_rd_val;

    modport master (
        output eei_req, eei_ext, eei_funct3, eei_funct7,
               eei_batch_start, eei_batch_len, eei_rs_val,
        input  eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val
    );

    modport slave (
        input  eei_req, eei_ext, eei_funct3, eei_funct7,
               eei_batch_start, eei_batch_len, eei_rs_val,
        output eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val
    );
endinterface

// File: rtl/eei_initiator.sv
// Core-side EEI initiator: latches a custom instruction, gathers batch operands,
// holds eei_req until ack, then writes results back. Optional REQ watchdog: SOPHON_EEI_TIMEOUT_EN.
module eei_initiator #(
    parameter int unsigned RS_MAX = 8,
    parameter int unsigned RD_MAX = 8
`ifdef SOPHON_EEI_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic        issue_ext_i,
    input  logic [2:0]  issue_funct3_i,
    input  logic [6:0]  issue_funct7_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [31:0] issue_rs1_val_i,
    input  logic [31:0] issue_rs2_val_i,
    input  logic [4:0]  issue_batch_start_i,
    input  logic [4:0]  issue_batch_len_i,
    input  logic        kill_i,
    output logic [4:0]  rf_raddr_o,
    input  logic [31:0] rf_rdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    eei_initiator_if.master eei
);

    typedef enum logic [2:0] {S_IDLE, S_GATHER, S_REQ, S_WB, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic                    ext_q, ext_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [6:0]              funct7_q, funct7_d;
    logic [4:0]              rd_q, rd_d;
    logic [4:0]              bstart_q, bstart_d;
    logic [4:0]              blen_q, blen_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [1:0]              rd_op_q, rd_op_d;
    logic [4:0]              rd_len_q, rd_len_d;
    logic                    err_q, err_d;
    logic                    req_q, req_d;
    logic [RS_MAX-1:0][31:0] rs_val_q, rs_val_d;
    logic [RD_MAX-1:0][31:0] rd_val_q, rd_val_d;
    logic [4:0]              seq_addr;
    logic [31:0]             wb_val;

`ifdef SOPHON_EEI_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    // Counter is held at zero outside REQ, so every REQ entry starts from zero.
    always_comb begin
        tmo_d   = (state_q == S_REQ) ? tmo_q + 1'b1 : '0;
        tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        ext_d      = ext_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        rd_d       = rd_q;
        bstart_d   = bstart_q;
        blen_d     = blen_q;
        cnt_d      = cnt_q;
        rd_op_d    = rd_op_q;
        rd_len_d   = rd_len_q;
        err_d      = err_q;
        rs_val_d   = rs_val_q;
        rd_val_d   = rd_val_q;
        rf_raddr_o = '0;
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        // A flush in IDLE refuses the instruction rather than accepting it.
        issue_ready_o = (state_q == S_IDLE) && !kill_i;
        seq_addr   = bstart_q + cnt_q;
        wb_val     = '0;
        for (int unsigned i = 0; i < RD_MAX; i++) begin
            if (i == 32'(cnt_q)) wb_val = rd_val_q[i];
        end

        unique case (state_q)
            S_IDLE: begin
                if (issue_valid_i && issue_ready_o) begin
                    ext_d    = issue_ext_i;
                    funct3_d = issue_funct3_i;
                    funct7_d = issue_funct7_i;
                    rd_d     = issue_rd_i;
                    bstart_d = issue_batch_start_i;
                    blen_d   = issue_batch_len_i;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    rs_val_d = '0;
                    if (!issue_ext_i) begin
                        rs_val_d[0] = issue_rs1_val_i;
                        rs_val_d[1] = issue_rs2_val_i;
                        state_d     = S_REQ;
                    end else if (32'(issue_batch_len_i) > RS_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (issue_batch_len_i == '0) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_GATHER;
                    end
                end
            end
            S_GATHER: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    // Slots past len were cleared at accept, so only slot k is written here.
                    rf_raddr_o = seq_addr;
                    for (int unsigned i = 0; i < RS_MAX; i++) begin
                        if (i == 32'(cnt_q)) rs_val_d[i] = (seq_addr == '0) ? '0 : rf_rdata_i;
                    end
                    if (cnt_q == blen_q - 5'd1) begin
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_REQ: begin
                if (eei.eei_ack) begin
                    err_d    = eei.eei_error;
                    rd_op_d  = eei.eei_rd_op;
                    rd_len_d = eei.eei_rd_len;
                    rd_val_d = eei.eei_rd_val;
                    cnt_d    = '0;
                    if (eei.eei_error) begin
                        state_d = S_DONE;
                    end else if ((eei.eei_rd_op == 2'd3) ||
                                 ((eei.eei_rd_op == 2'd2) && (32'(eei.eei_rd_len) > RD_MAX))) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if ((eei.eei_rd_op == 2'd0) ||
                                 ((eei.eei_rd_op == 2'd2) && (eei.eei_rd_len == '0))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WB;
                    end
                end
`ifdef SOPHON_EEI_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_WB: begin
                if (rd_op_q == 2'd1) begin
                    rf_we_o    = (rd_q != '0);
                    rf_waddr_o = rd_q;
                    rf_wdata_o = rd_val_q[0];
                    state_d    = S_DONE;
                end else begin
                    // x0 slots still take their cycle so batch timing stays fixed.
                    rf_we_o    = (seq_addr != '0);
                    rf_waddr_o = seq_addr;
                    rf_wdata_o = wb_val;
                    if (cnt_q == rd_len_q - 5'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            ext_q    <= 1'b0;
            funct3_q <= '0;
            funct7_q <= '0;
            rd_q     <= '0;
            bstart_q <= '0;
            blen_q   <= '0;
            cnt_q    <= '0;
            rd_op_q  <= '0;
            rd_len_q <= '0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            rs_val_q <= '0;
            rd_val_q <= '0;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            rd_q     <= rd_d;
            bstart_q <= bstart_d;
            blen_q   <= blen_d;
            cnt_q    <= cnt_d;
            rd_op_q  <= rd_op_d;
            rd_len_q <= rd_len_d;
            err_q    <= err_d;
            req_q    <= req_d;
            rs_val_q <= rs_val_d;
            rd_val_q <= rd_val_d;
        end
    end

    assign busy_o              = (state_q != S_IDLE);
    assign done_o              = (state_q == S_DONE);
    assign error_o             = done_o && err_q;
    assign eei.eei_req         = req_q;
    assign eei.eei_ext         = ext_q;
    assign eei.eei_funct3      = funct3_q;
    assign eei.eei_funct7      = funct7_q;
    assign eei.eei_batch_start = bstart_q;
    assign eei.eei_batch_len   = blen_q;
    assign eei.eei_rs_val      = rs_val_q;

endmodule

// File: doc/eei_initiator.md
Name: eei_initiator

Overview:
- Core-side master of the EEI custom-instruction interface; drives the eei_* request to the custom execution units and consumes their response.
- Accepts one decoded custom instruction from the execute stage and latches its operands.
- For ext (batch) instructions, gathers source registers one per cycle through a regfile read port.
- Holds eei_req until eei_ack, then writes results back (none, single rd, or batch), one register per cycle through a regfile write port, and reports completion or error to the core.

Parameters:
- RS_MAX, 8, number of eei_rs_val operand slots
- RD_MAX, 8, number of eei_rd_val result slots
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with EEI_TIMEOUT_EN

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous reset, active-low
- issue_valid_i  in  1  custom instruction presented
- issue_ready_o  out  1  high only in IDLE; accept = valid & ready
- issue_ext_i  in  1  ext/batch instruction
- issue_funct3_i  in  3  funct3
- issue_funct7_i  in  7  funct7
- issue_rd_i  in  5  destination register for single writeback
- issue_rs1_val_i / issue_rs2_val_i  in  32 each  non-ext operands
- issue_batch_start_i  in  5  first register of the batch
- issue_batch_len_i  in  5  batch register count
- kill_i  in  1  pipeline flush
- rf_raddr_o  out  5  gather read address
- rf_rdata_i  in  32  read data, combinational, same cycle as address
- rf_we_o / rf_waddr_o / rf_wdata_o  out  1/5/32  writeback port
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  valid with done_o; raises illegal-instruction exception
- eei_req / eei_ext / eei_funct3 / eei_funct7 / eei_batch_start / eei_batch_len  out  1/1/3/7/5/5  request fields, all registered
- eei_rs_val  out  RS_MAX x 32  operand array
- eei_ack / eei_error  in  1/1  response strobe and error flag
- eei_rd_op  in  2  0 = no write, 1 = single, 2 = batch, 3 = illegal
- eei_rd_len  in  5  batch write count
- eei_rd_val  in  RD_MAX x 32  result array

Behaviour:
- Reset (rst_ni=0 sampled at clk_i edge): state = IDLE; all outputs 0 except issue_ready_o = 1; operand and result buffers cleared.
  - Reset mid-operation abandons the instruction immediately: no done_o, no further rf writes.
- IDLE, on accept: latch all issue fields.
  - non-ext: rs_val[0] = rs1, rs_val[1] = rs2, other slots 0; go to REQ.
  - ext, batch_len > RS_MAX: go to DONE with error, no eei_req.
  - ext, batch_len = 0: all slots 0; go to REQ.
  - ext, otherwise: go to GATHER.
- GATHER: cycle k drives rf_raddr_o = (batch_start + k) mod 32 and captures rs_val[k] = rf_rdata_i, for k = 0 .. len-1.
  - Then zero the remaining slots and go to REQ.
  - Reads of x0 return 0.
  - kill_i in IDLE or GATHER returns to IDLE with no done_o. kill_i is ignored from REQ onward.
- REQ: eei_req = 1 and all request fields held stable.
  - On the cycle eei_ack = 1, latch eei_error, eei_rd_op, eei_rd_len and eei_rd_val; eei_req drops the next cycle.
  - A combinational ack in the first REQ cycle is legal.
- After ack, priority order:
  - eei_error: DONE with error.
  - rd_op = 3, or rd_op = 2 with rd_len > RD_MAX: DONE with error.
  - rd_op = 0, or rd_op = 2 with rd_len = 0: DONE, no writes.
  - Otherwise: go to WB.
- WB, single: one cycle with rf_we_o = (rd != 0), rf_waddr_o = rd, rf_wdata_o = rd_val[0].
- WB, batch: cycle j writes rd_val[j] to (batch_start + j) mod 32, for j = 0 .. rd_len-1.
  - Wrap-around past x31 is allowed.
  - Writes to x0 are suppressed (rf_we_o = 0) but still consume the cycle.
- DONE: done_o = 1 for exactly one cycle, error_o valid; next state IDLE.
  - An issue can be accepted on the cycle after DONE.
- Minimum latency, non-ext single write with combinational ack:
  - accept at cycle 0, REQ at cycle 1, WB at cycle 2, done_o at cycle 3.

Optional Feature:
- Macro: SOPHON_EEI_TIMEOUT_EN.
- Defined: a counter runs in REQ. If eei_ack is not seen after TIMEOUT_CYCLES cycles, eei_req drops, no writeback occurs, and the block goes to DONE with error_o = 1. The counter clears on REQ entry.
- Undefined: REQ waits indefinitely; no counter logic is present.

Test Plan:
- Non-ext, rs1 = 0x5, rs2 = 0xA, rd = 7; responder acks the same cycle with rd_op = 1, rd_val[0] = 0x1234 -> exactly one write x7 = 0x1234; done_o at cycle 3; error_o = 0.
- Ext gather, batch_start = 30, len = 4; regfile xN = N, x0 = 0 -> read addresses 30, 31, 0, 1; eei_rs_val = {30, 31, 0, 1, 0, 0, 0, 0}; eei_req held 5 cycles until a delayed ack.
- Batch writeback, rd_op = 2, rd_len = 3, batch_start = 31, rd_val = {A, B, C} -> x31 = A; x0 write suppressed; x1 = C; done_o follows.
- Ack with eei_error = 1, or rd_op = 3, or rd_len = 9 -> no rf_we_o; done_o = 1 with error_o = 1. Ext with batch_len = 9 -> error, eei_req never asserted.
- kill_i during GATHER returns to IDLE with no req and no done_o. Reset asserted during WB stops writes the next cycle; after reset, issue_ready_o = 1.
- With SOPHON_EEI_TIMEOUT_EN and TIMEOUT_CYCLES = 16, ack never given -> eei_req falls after 16 cycles; done_o with error_o = 1.
